// File: rtl/cpu_pkg.sv
// Shared CPU fetch definitions: PC generator states, next-PC source codes
// and default reset/exception vector addresses.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_EXC,
        ST_HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_JR,
        SRC_RAS,
        SRC_EXCV,
        SRC_EPC,
        SRC_HOLD
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0040_0180;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Ports: i_clk (falling-edge), i_rst (sync, active-high), i_push, i_pop,
//        i_data (link to push), o_top, o_count, o_empty, o_full.
module pc_ras
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [ADDR_W-1:0]              i_data,
    output logic [ADDR_W-1:0]              o_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] o_count,
    output logic                           o_empty,
    output logic                           o_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     w_top_idx;
    logic              w_pop;

    // r_ptr is the next free slot; the top sits just below it.
    assign w_top_idx = r_ptr - PW'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_count   = r_cnt;
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(RAS_DEPTH));
    assign w_pop     = i_pop & ~o_empty;

    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push && w_pop) begin
            // Pop-then-push: depth unchanged, top replaced in place.
            r_mem[w_top_idx] <= i_data;
        end else if (i_push) begin
            r_mem[r_ptr] <= i_data;
            r_ptr        <= r_ptr + PW'(1);
            if (!o_full) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (w_pop) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: next-PC selection, boot/run/handler/halt FSM,
// EPC and return-address stack. All state changes on the falling pc_clk edge.
// Ports: pc_clk, rst_n (sync, active-high), pc_ena, stall, br_taken/br_target,
//        jmp/jmp_target, jr/jr_target, call, ret, exc_req, eret, halt_req,
//        resume -> pc_addr_out, pc_valid, epc_out, in_exc, misalign, ras_miss.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
    parameter int                INST_BYTES = 4,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              pc_clk,
    input  logic              rst_n,
    input  logic              pc_ena,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              call,
    input  logic              ret,
    input  logic              exc_req,
    input  logic              eret,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_addr_out,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] epc_out,
    output logic              in_exc,
    output logic              misalign,
    output logic              ras_miss
);

    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(INST_BYTES - 1);
    localparam int                CW    = $clog2(RAS_DEPTH + 1);

    pc_state_e         r_state;
    pc_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic              r_misalign;
    logic              r_ras_miss;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_pc_nxt;
    pc_src_e           w_sel;
    pc_src_e           w_src;
    logic              w_redir;
    logic              w_chk;
    logic              w_miss_sel;
    logic              w_bad;
    logic              w_epc_we;
    logic              w_push;
    logic              w_pop;
    logic              w_mis;
    logic              w_miss;

    logic [ADDR_W-1:0] w_ras_top;
    logic [CW-1:0]     w_ras_cnt_unused;
    logic              w_ras_empty;
    logic              w_ras_full_unused;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (pc_clk),
        .i_rst   (rst_n),
        .i_push  (w_push & pc_ena),
        .i_pop   (w_pop & pc_ena),
        .i_data  (w_seq),
        .o_top   (w_ras_top),
        .o_count (w_ras_cnt_unused),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full_unused)
    );

    assign w_seq   = r_pc + STEP;
    assign w_redir = br_taken | jmp | jr | ret;

    // Redirect target by priority; a ret on an empty stack falls back to
    // jr_target and is alignment-checked like a jr.
    always_comb begin
        w_sel      = SRC_SEQ;
        w_tgt      = w_seq;
        w_chk      = 1'b0;
        w_miss_sel = 1'b0;
        if (br_taken) begin
            w_sel = SRC_BR;
            w_tgt = br_target;
            w_chk = 1'b1;
        end else if (jmp) begin
            w_sel = SRC_JMP;
            w_tgt = jmp_target;
            w_chk = 1'b1;
        end else if (jr) begin
            w_sel = SRC_JR;
            w_tgt = jr_target;
            w_chk = 1'b1;
        end else if (ret && !w_ras_empty) begin
            w_sel = SRC_RAS;
            w_tgt = w_ras_top;
        end else if (ret) begin
            w_sel      = SRC_JR;
            w_tgt      = jr_target;
            w_chk      = 1'b1;
            w_miss_sel = 1'b1;
        end
    end

    assign w_bad = w_chk & ((w_tgt & AMASK) != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_src       = SRC_HOLD;
        w_epc_we    = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_mis       = 1'b0;
        w_miss      = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
                w_src       = SRC_SEQ;
            end
            ST_HALT: begin
                if (exc_req) begin
                    w_state_nxt = ST_EXC;
                    w_src       = SRC_EXCV;
                    w_epc_we    = 1'b1;
                end else if (resume && !halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                if (r_state == ST_RUN && exc_req) begin
                    w_state_nxt = ST_EXC;
                    w_src       = SRC_EXCV;
                    w_epc_we    = 1'b1;
                end else if (r_state == ST_EXC && eret) begin
                    w_state_nxt = ST_RUN;
                    w_src       = SRC_EPC;
                end else if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (stall) begin
                    w_src = SRC_HOLD;
                end else if (w_redir) begin
                    w_miss = w_miss_sel;
                    if (w_bad) begin
                        // Trap: target dropped, no push; nested
                        // traps keep the original EPC.
                        w_mis = 1'b1;
                        w_src = SRC_EXCV;
                        if (r_state == ST_RUN) begin
                            w_state_nxt = ST_EXC;
                            w_epc_we    = 1'b1;
                        end
                    end else begin
                        w_src  = w_sel;
                        w_pop  = (w_sel == SRC_RAS);
                        w_push = call & ((w_sel == SRC_JMP) |
                                         (w_sel == SRC_JR) |
                                         (w_sel == SRC_RAS));
                    end
                end else begin
                    w_src = SRC_SEQ;
                end
            end
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        unique case (w_src)
            SRC_SEQ:  w_pc_nxt = w_seq;
            SRC_BR,
            SRC_JMP,
            SRC_JR,
            SRC_RAS:  w_pc_nxt = w_tgt;
            SRC_EXCV: w_pc_nxt = EXC_VEC;
            SRC_EPC:  w_pc_nxt = r_epc;
            default:  w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(negedge pc_clk) begin
        if (rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_misalign <= 1'b0;
            r_ras_miss <= 1'b0;
        end else if (pc_ena) begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= w_mis;
            r_ras_miss <= w_miss;
            if (w_epc_we) begin
                r_epc <= r_pc;
            end
        end else begin
            r_misalign <= 1'b0;
            r_ras_miss <= 1'b0;
        end
    end

    assign pc_addr_out = r_pc;
    assign epc_out     = r_epc;
    assign pc_valid    = (r_state == ST_RUN) | (r_state == ST_EXC);
    assign in_exc      = (r_state == ST_EXC);
    assign misalign    = r_misalign;
    assign ras_miss    = r_ras_miss;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen (32-bit default and an 8-bit wrap
// instance). Outputs change on falling edges and are sampled on rising edges.
module tb_pc_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pc_ena, stall, br_taken, jmp, jr, call, ret;
    logic        exc_req, eret, halt_req, resume;
    logic [31:0] br_target, jmp_target, jr_target;
    logic [31:0] pc, epc;
    logic        valid, in_exc, misalign, ras_miss;

    logic        z1;
    logic [7:0]  z8;
    logic [7:0]  w8_pc, w8_epc_unused;
    logic        w8_v_unused, w8_x_unused, w8_m_unused, w8_r_unused;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        v;
        logic [31:0] epc;
        logic        x;
        logic        m;
        logic        r;
    } exp_t;

    exp_t sb[$];

    pc_gen dut (
        .pc_clk      (clk),
        .rst_n       (rst_n),
        .pc_ena      (pc_ena),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .jr          (jr),
        .jr_target   (jr_target),
        .call        (call),
        .ret         (ret),
        .exc_req     (exc_req),
        .eret        (eret),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc_addr_out (pc),
        .pc_valid    (valid),
        .epc_out     (epc),
        .in_exc      (in_exc),
        .misalign    (misalign),
        .ras_miss    (ras_miss)
    );

    pc_gen #(
        .ADDR_W    (8),
        .RESET_VEC (8'hFC),
        .EXC_VEC   (8'h80),
        .RAS_DEPTH (2)
    ) dut8 (
        .pc_clk      (clk),
        .rst_n       (rst_n),
        .pc_ena      (1'b1),
        .stall       (z1),
        .br_taken    (z1),
        .br_target   (z8),
        .jmp         (z1),
        .jmp_target  (z8),
        .jr          (z1),
        .jr_target   (z8),
        .call        (z1),
        .ret         (z1),
        .exc_req     (z1),
        .eret        (z1),
        .halt_req    (z1),
        .resume      (z1),
        .pc_addr_out (w8_pc),
        .pc_valid    (w8_v_unused),
        .epc_out     (w8_epc_unused),
        .in_exc      (w8_x_unused),
        .misalign    (w8_m_unused),
        .ras_miss    (w8_r_unused)
    );

    task automatic cmp(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        @(posedge clk);
        if (sb.size() == 0) begin
            cmp("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".pc"}, pc, e.pc);
            cmp({e.tag, ".valid"}, {31'd0, valid}, {31'd0, e.v});
            cmp({e.tag, ".epc"}, epc, e.epc);
            cmp({e.tag, ".in_exc"}, {31'd0, in_exc}, {31'd0, e.x});
            cmp({e.tag, ".misalign"}, {31'd0, misalign}, {31'd0, e.m});
            cmp({e.tag, ".ras_miss"}, {31'd0, ras_miss}, {31'd0, e.r});
        end
    endtask

    task automatic st(input string tag, input logic [31:0] p,
                      input logic v, input logic [31:0] ep,
                      input logic x, input logic m, input logic r);
        exp_t e;
        e.tag = tag;
        e.pc  = p;
        e.v   = v;
        e.epc = ep;
        e.x   = x;
        e.m   = m;
        e.r   = r;
        sb.push_back(e);
        tick();
    endtask

    localparam logic [31:0] B = 32'h0040_0000;

    initial begin
        rst_n = 1'b1; pc_ena = 1'b1; stall = 1'b0;
        br_taken = 1'b0; jmp = 1'b0; jr = 1'b0; call = 1'b0; ret = 1'b0;
        exc_req = 1'b0; eret = 1'b0; halt_req = 1'b0; resume = 1'b0;
        br_target = '0; jmp_target = '0; jr_target = '0;
        z1 = 1'b0; z8 = '0;
        @(posedge clk);

        st("rst0", B, 0, 0, 0, 0, 0);
        cmp("wrap_rst", {24'd0, w8_pc}, 32'h0000_00FC);
        st("rst1", B, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        st("run0", B + 32'h4, 1, 0, 0, 0, 0);
        cmp("wrap0", {24'd0, w8_pc}, 32'h0000_0000);
        st("run1", B + 32'h8, 1, 0, 0, 0, 0);
        cmp("wrap1", {24'd0, w8_pc}, 32'h0000_0004);

        stall = 1'b1; br_taken = 1'b1; br_target = B + 32'h100;
        st("stall_br", B + 32'h8, 1, 0, 0, 0, 0);
        stall = 1'b0;
        st("br", B + 32'h100, 1, 0, 0, 0, 0);
        br_taken = 1'b0;
        st("br_seq", B + 32'h104, 1, 0, 0, 0, 0);

        jmp = 1'b1; jmp_target = B + 32'h10;
        st("jmp", B + 32'h10, 1, 0, 0, 0, 0);
        jmp = 1'b0; exc_req = 1'b1;
        st("exc", B + 32'h180, 1, B + 32'h10, 1, 0, 0);
        st("exc_again", B + 32'h184, 1, B + 32'h10, 1, 0, 0);
        exc_req = 1'b0; eret = 1'b1;
        st("eret", B + 32'h10, 1, B + 32'h10, 0, 0, 0);
        eret = 1'b0;
        st("eret_seq", B + 32'h14, 1, B + 32'h10, 0, 0, 0);

        for (int i = 1; i <= 5; i++) begin
            jmp = 1'b1; call = 1'b0;
            jmp_target = B + 32'(i * 16);
            st("ras_pos", B + 32'(i * 16), 1, B + 32'h10, 0, 0, 0);
            call = 1'b1; jmp_target = B + 32'h300;
            st("ras_call", B + 32'h300, 1, B + 32'h10, 0, 0, 0);
        end
        call = 1'b0; jmp = 1'b0;

        ret = 1'b1;
        st("ret1", B + 32'h54, 1, B + 32'h10, 0, 0, 0);
        st("ret2", B + 32'h44, 1, B + 32'h10, 0, 0, 0);
        st("ret3", B + 32'h34, 1, B + 32'h10, 0, 0, 0);
        st("ret4", B + 32'h24, 1, B + 32'h10, 0, 0, 0);
        jr_target = B + 32'h200;
        st("ret_miss", B + 32'h200, 1, B + 32'h10, 0, 0, 1);
        ret = 1'b0;
        st("miss_seq", B + 32'h204, 1, B + 32'h10, 0, 0, 0);

        jmp = 1'b1; jmp_target = B + 32'h102;
        st("misalign", B + 32'h180, 1, B + 32'h204, 1, 1, 0);
        jmp = 1'b0;
        st("mis_seq", B + 32'h184, 1, B + 32'h204, 1, 0, 0);
        eret = 1'b1;
        st("mis_eret", B + 32'h204, 1, B + 32'h204, 0, 0, 0);
        eret = 1'b0;
        st("mis_run", B + 32'h208, 1, B + 32'h204, 0, 0, 0);

        halt_req = 1'b1;
        st("halt", B + 32'h208, 0, B + 32'h204, 0, 0, 0);
        halt_req = 1'b0;
        st("halt_hold", B + 32'h208, 0, B + 32'h204, 0, 0, 0);
        resume = 1'b1;
        st("resume", B + 32'h208, 1, B + 32'h204, 0, 0, 0);
        resume = 1'b0;
        st("resume_seq", B + 32'h20C, 1, B + 32'h204, 0, 0, 0);

        pc_ena = 1'b0; jmp = 1'b1; jmp_target = B + 32'h400;
        for (int i = 0; i < 3; i++) begin
            st("ena_off", B + 32'h20C, 1, B + 32'h204, 0, 0, 0);
        end
        pc_ena = 1'b1; jmp = 1'b0;
        st("ena_on", B + 32'h210, 1, B + 32'h204, 0, 0, 0);

        rst_n = 1'b1;
        st("mid_rst", B, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        st("mid_boot", B + 32'h4, 1, 0, 0, 0, 0);

        cmp("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
